// File: rtl/copia_memoria_pkg.sv
// Shared definitions for the ROM-to-RAM copy controller: FSM state encoding
// and copy direction constants.
package copia_memoria_pkg;

  typedef enum logic [3:0] {
    INICIO       = 4'b0000,
    CONFIG_END   = 4'b0001,
    LER_ROM      = 4'b0010,
    ESCREVER_RAM = 4'b0011,
    AVANCA       = 4'b0100,
    VERIF_END    = 4'b0101,
    LER_RAM      = 4'b0110,
    COMPARA      = 4'b0111,
    ENCERRAR     = 4'b1000
  } estado_t;

  localparam logic MODO_DIRETO  = 1'b0;
  localparam logic MODO_REVERSO = 1'b1;

endpackage

// File: rtl/copia_memoria_endereco.sv
// Maps the source index to the RAM destination address for direct or
// reversed copies; shared by the copy and verify passes.
module copia_memoria_endereco
  import copia_memoria_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic [ADDR_W-1:0] i,
  input  logic              modo,
  output logic [ADDR_W-1:0] dst
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);

  assign dst = (modo == MODO_REVERSO) ? (ULTIMO - i) : i;

endmodule

// File: rtl/copia_memoria_ctrl.sv
// ROM-to-RAM copy controller with optional read-back verify pass.
// Define COPIA_VERIFICA_EN to compile in the verify states.
module copia_memoria_ctrl
  import copia_memoria_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              modo,
  output logic [ADDR_W-1:0] a_rom,
  output logic              rom_rden,
  input  logic [DATA_W-1:0] q_rom,
  output logic [ADDR_W-1:0] a_ram,
  output logic              ram_rden,
  output logic              wren,
  output logic [DATA_W-1:0] d_ram,
  input  logic [DATA_W-1:0] q_ram,
  output logic [ADDR_W-1:0] i,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [ADDR_W-1:0] erro_addr
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);

  estado_t           estado, proximo;
  logic              modo_q;
  logic [ADDR_W-1:0] i_q, a_rom_q, a_ram_q, dst;
  logic              ultimo;

  copia_memoria_endereco #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_endereco (
    .i    (i_q),
    .modo (modo_q),
    .dst  (dst)
  );

  assign ultimo = (i_q == ULTIMO);
  assign i      = i_q;
  assign busy   = (estado != INICIO);

  // Addresses are driven live in the states that own them and otherwise
  // replay the registered copy, so they hold their last value.
  always_comb begin
    proximo  = estado;
    a_rom    = a_rom_q;
    a_ram    = a_ram_q;
    rom_rden = 1'b0;
    ram_rden = 1'b0;
    wren     = 1'b0;
    d_ram    = '0;
    done     = 1'b0;
    case (estado)
      INICIO:       if (start) proximo = CONFIG_END;
      CONFIG_END: begin
        a_rom    = i_q;
        rom_rden = 1'b1;
        proximo  = LER_ROM;
      end
      LER_ROM:      proximo = ESCREVER_RAM;
      ESCREVER_RAM: begin
        a_ram   = dst;
        d_ram   = q_rom;
        wren    = 1'b1;
        proximo = AVANCA;
      end
      AVANCA: begin
        if (!ultimo)
          proximo = CONFIG_END;
        else
`ifdef COPIA_VERIFICA_EN
          proximo = VERIF_END;
`else
          proximo = ENCERRAR;
`endif
      end
`ifdef COPIA_VERIFICA_EN
      VERIF_END: begin
        a_rom    = i_q;
        a_ram    = dst;
        rom_rden = 1'b1;
        ram_rden = 1'b1;
        proximo  = LER_RAM;
      end
      LER_RAM:      proximo = COMPARA;
      COMPARA:      proximo = (q_ram != q_rom || ultimo) ? ENCERRAR : VERIF_END;
`endif
      ENCERRAR: begin
        done    = 1'b1;
        proximo = INICIO;
      end
      default:      proximo = INICIO;
    endcase
  end

`ifdef COPIA_VERIFICA_EN
  logic              erro_q;
  logic [ADDR_W-1:0] erro_addr_q;
  assign erro      = erro_q;
  assign erro_addr = erro_addr_q;
`else
  logic unused_q_ram;
  assign unused_q_ram = ^q_ram;
  assign erro         = 1'b0;
  assign erro_addr    = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= INICIO;
      modo_q  <= MODO_DIRETO;
      i_q     <= '0;
      a_rom_q <= '0;
      a_ram_q <= '0;
`ifdef COPIA_VERIFICA_EN
      erro_q      <= 1'b0;
      erro_addr_q <= '0;
`endif
    end else begin
      estado  <= proximo;
      a_rom_q <= a_rom;
      a_ram_q <= a_ram;
      case (estado)
        INICIO: if (start) begin
          modo_q <= modo;
          i_q    <= '0;
`ifdef COPIA_VERIFICA_EN
          erro_q      <= 1'b0;
          erro_addr_q <= '0;
`endif
        end
        AVANCA: i_q <= ultimo ? '0 : i_q + 1'b1;
`ifdef COPIA_VERIFICA_EN
        COMPARA: begin
          if (q_ram != q_rom) begin
            erro_q      <= 1'b1;
            erro_addr_q <= dst;
          end else if (!ultimo) begin
            i_q <= i_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_copia_memoria_ctrl.sv
// Scoreboard bench for copia_memoria_ctrl: a DEPTH=32 and a DEPTH=1 instance
// with behavioural synchronous ROM/RAM models.
module tb_copia_memoria_ctrl;

`ifdef COPIA_VERIFICA_EN
  localparam int DONE_A = 225;
  localparam int DONE_B = 8;
`else
  localparam int DONE_A = 129;
  localparam int DONE_B = 5;
`endif

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int cyc; int erro; int ea; } dn_t;

  logic clock = 1'b0, reset = 1'b1, modo = 1'b0, fault = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clock = ~clock;

  logic [4:0] a_rom_a, a_ram_a, i_a, erro_addr_a, a_rom_b, a_ram_b, i_b, erro_addr_b;
  logic       rom_rden_a, ram_rden_a, wren_a, busy_a, done_a, erro_a;
  logic       rom_rden_b, ram_rden_b, wren_b, busy_b, done_b, erro_b;
  logic [7:0] d_ram_a, d_ram_b;
  logic [7:0] q_rom_a = '0, q_ram_a = '0, q_rom_b = '0, q_ram_b = '0;

  copia_memoria_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .modo(modo),
    .a_rom(a_rom_a), .rom_rden(rom_rden_a), .q_rom(q_rom_a),
    .a_ram(a_ram_a), .ram_rden(ram_rden_a), .wren(wren_a), .d_ram(d_ram_a),
    .q_ram(q_ram_a), .i(i_a), .busy(busy_a), .done(done_a),
    .erro(erro_a), .erro_addr(erro_addr_a));

  copia_memoria_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(1)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .modo(modo),
    .a_rom(a_rom_b), .rom_rden(rom_rden_b), .q_rom(q_rom_b),
    .a_ram(a_ram_b), .ram_rden(ram_rden_b), .wren(wren_b), .d_ram(d_ram_b),
    .q_ram(q_ram_b), .i(i_b), .busy(busy_b), .done(done_b),
    .erro(erro_b), .erro_addr(erro_addr_b));

  logic [7:0] rom_a [32];
  logic [7:0] ram_a [32];
  logic [7:0] rom_b = 8'h5A, ram_b = 8'h00;

  always @(posedge clock) begin
    if (rom_rden_a) q_rom_a <= rom_a[a_rom_a];
    if (ram_rden_a) q_ram_a <= (fault && a_ram_a == 5'd5) ? 8'hFF : ram_a[a_ram_a];
    if (wren_a)     ram_a[a_ram_a] <= d_ram_a;
    if (rom_rden_b) q_rom_b <= rom_b;
    if (ram_rden_b) q_ram_b <= ram_b;
    if (wren_b)     ram_b <= d_ram_b;
  end

  int cyc = 0, base_a = 0, base_b = 0;
  int passed = 0, total = 0;
  int rd_rom_a = 0, rd_ram_a = 0;
  wr_t wq_a[$], wq_b[$];
  dn_t dq_a[$], dq_b[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic miss(input string name, input string what);
    total++;
    $display("FAIL %s: %s", name, what);
  endtask

  always @(negedge clock) begin : mon_a
    wr_t w;
    dn_t d;
    if (!reset) begin
      if (rom_rden_a) rd_rom_a++;
      if (ram_rden_a) rd_ram_a++;
      if (wren_a) begin
        if (wq_a.size() == 0) miss("a_wren", "write with nothing expected");
        else begin
          w = wq_a.pop_front();
          chk("a_wr_addr", a_ram_a, w.addr);
          chk("a_wr_data", d_ram_a, w.data);
          chk("a_wr_cycle", cyc - base_a, w.cyc);
        end
      end
      if (done_a) begin
        if (dq_a.size() == 0) miss("a_done", "done with nothing expected");
        else begin
          d = dq_a.pop_front();
          chk("a_done_cycle", cyc - base_a, d.cyc);
          chk("a_erro", erro_a, d.erro);
          chk("a_erro_addr", erro_addr_a, d.ea);
        end
      end
    end
  end

  always @(negedge clock) begin : mon_b
    wr_t w;
    dn_t d;
    if (!reset) begin
      if (wren_b) begin
        if (wq_b.size() == 0) miss("b_wren", "write with nothing expected");
        else begin
          w = wq_b.pop_front();
          chk("b_wr_addr", a_ram_b, w.addr);
          chk("b_wr_data", d_ram_b, w.data);
          chk("b_wr_cycle", cyc - base_b, w.cyc);
        end
      end
      if (done_b) begin
        if (dq_b.size() == 0) miss("b_done", "done with nothing expected");
        else begin
          d = dq_b.pop_front();
          chk("b_done_cycle", cyc - base_b, d.cyc);
          chk("b_erro", erro_b, d.erro);
        end
      end
    end
  end

  task automatic push_a(input logic m, input int n);
    for (int k = 0; k < n; k++)
      wq_a.push_back('{addr: m ? 31 - k : k, data: int'(rom_a[k]), cyc: 3 + 4 * k});
  endtask

  task automatic go_a(input logic m);
    @(negedge clock);
    base_a   = cyc;
    rd_rom_a = 0;
    rd_ram_a = 0;
    modo     = m;
    start_a  = 1'b1;
    @(negedge clock);
    start_a  = 1'b0;
  endtask

  task automatic wait_a(input string name);
    for (int n = 0; n < 400 && dq_a.size() != 0; n++) @(posedge clock);
    if (dq_a.size() != 0) begin
      miss(name, "timeout waiting for done");
      dq_a.delete();
    end
    @(negedge clock);
    chk({name, "_leftover_writes"}, wq_a.size(), 0);
    wq_a.delete();
  endtask

  task automatic run_b(input logic m, input logic [7:0] val);
    rom_b = val;
    wq_b.push_back('{addr: 0, data: int'(val), cyc: 3});
    dq_b.push_back('{cyc: DONE_B, erro: 0, ea: 0});
    @(negedge clock);
    base_b  = cyc;
    modo    = m;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    for (int n = 0; n < 50 && dq_b.size() != 0; n++) @(posedge clock);
    if (dq_b.size() != 0) begin
      miss("b_run", "timeout waiting for done");
      dq_b.delete();
    end
    @(negedge clock);
    chk("b_leftover_writes", wq_b.size(), 0);
    wq_b.delete();
    chk("b_ram_contents", ram_b, val);
  endtask

  initial begin
    int bad;
    for (int k = 0; k < 32; k++) begin
      rom_a[k] = 8'(k) + 8'h40;
      ram_a[k] = 8'h00;
    end
    repeat (3) @(negedge clock);
    chk("a_reset_outputs", {a_rom_a, rom_rden_a, a_ram_a, ram_rden_a, wren_a, d_ram_a,
                            i_a, busy_a, done_a, erro_a, erro_addr_a}, 0);
    chk("b_reset_outputs", {a_rom_b, rom_rden_b, a_ram_b, ram_rden_b, wren_b, d_ram_b,
                            i_b, busy_b, done_b, erro_b, erro_addr_b}, 0);
    reset = 1'b0;

    // Reversed copy of the full ROM.
    push_a(1'b1, 32);
    dq_a.push_back('{cyc: DONE_A, erro: 0, ea: 0});
    go_a(1'b1);
    chk("a_busy_cycle1", busy_a, 1);
    wait_a("a_rev");
    bad = 0;
    for (int k = 0; k < 32; k++) if (ram_a[31 - k] != rom_a[k]) bad++;
    chk("a_rev_ram_mismatches", bad, 0);
    chk("a_rev_erro", erro_a, 0);

    // Direct copy with start pulses at cycles 3 and 50 that must be ignored.
    push_a(1'b0, 32);
    dq_a.push_back('{cyc: DONE_A, erro: 0, ea: 0});
    go_a(1'b0);
    repeat (2) @(negedge clock);
    start_a = 1'b1; modo = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (46) @(negedge clock);
    chk("a_cycle50_busy", busy_a, 1);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0; modo = 1'b0;
    wait_a("a_dir");
    bad = 0;
    for (int k = 0; k < 32; k++) if (ram_a[k] != rom_a[k]) bad++;
    chk("a_dir_ram_mismatches", bad, 0);
    repeat (20) @(negedge clock);
    chk("a_idle_after_done", busy_a, 0);

`ifdef COPIA_VERIFICA_EN
    // Verify pass with RAM[5] reading back corrupted.
    fault = 1'b1;
    push_a(1'b0, 32);
    dq_a.push_back('{cyc: 147, erro: 1, ea: 5});
    go_a(1'b0);
    wait_a("a_fault");
    repeat (5) @(negedge clock);
    chk("a_fault_ram_reads", rd_ram_a, 6);
    chk("a_fault_rom_reads", rd_rom_a, 38);
    chk("a_fault_erro_held", erro_a, 1);
    chk("a_fault_addr_held", erro_addr_a, 5);
    fault = 1'b0;
`endif

    // Reset asserted at cycle 10 aborts the copy after two writes.
    push_a(1'b0, 2);
    go_a(1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("a_midreset_outputs", {a_rom_a, rom_rden_a, a_ram_a, ram_rden_a, wren_a, d_ram_a,
                               i_a, busy_a, done_a, erro_a, erro_addr_a}, 0);
    reset = 1'b0;
    chk("a_midreset_leftover", wq_a.size(), 0);
    wq_a.delete();

    push_a(1'b1, 32);
    dq_a.push_back('{cyc: DONE_A, erro: 0, ea: 0});
    go_a(1'b1);
    chk("a_erro_cleared_on_start", erro_a, 0);
    wait_a("a_after_reset");

    run_b(1'b0, 8'h5A);
    run_b(1'b1, 8'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
